video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised raster timing generator for the video subsystem, replacing the fixed 341×262 counter logic. It divides the system clock into a pixel strobe and produces pixel/line counters, active-area, hsync and vsync with configurable porches and polarity. It also exposes a small host register file with a vblank flag and level NMI, a programmable raster-line interrupt, and an optional odd-frame short line. Pixel fetch, palette and output stages consume its counters and strobe.

## Interface
- P_div, 4: system clocks per pixel (≥2)
- P_active_h, 256: active pixels per line
- P_front_h, 9: horizontal front porch, pixels
- P_sync_h, 51: hsync width, pixels
- P_back_h, 25: horizontal back porch, pixels
- P_active_v, 240: active lines per frame
- P_front_v, 5: vertical front porch, lines
- P_sync_v, 1: vsync width, lines
- P_back_v, 16: vertical back porch, lines
- P_vblank_line, P_active_v+1: line on which the vblank flag sets
- P_hsync_pol / P_vsync_pol, 0 / 0: 1 = sync pulse high, 0 = sync pulse low
- P_cnt_width, 10: counter width; must hold H_total−1 and V_total−1, ≤10
- I_clock  in  1  system clock
- I_reset  in  1  reset; one clock, reset is asynchronous and active-high
- O_pix_rise  out  1  one-clock pixel strobe
- O_hcount  out  P_cnt_width  current pixel, 0..H_total−1
- O_vcount  out  P_cnt_width  current line, 0..V_total−1
- O_active  out  1  high inside the active area
- O_hsync / O_vsync  out  1  sync outputs, parameter polarity
- O_frame_odd  out  1  frame parity
- I_host_addr  in  2  register select
- I_host_wren / I_host_rden  in  1  one-clock write / read strobes, mutually exclusive
- I_host_data  in  8  write data
- O_host_data  out  8  read data, registered
- O_host_nmi  out  1  vblank & nmi_en, level
- O_raster_irq  out  1  raster_hit & irq_en, level

## Operation
- H_total = sum of the four h params; V_total = sum of the four v params.
- Divider counts 0..P_div−1. O_pix_rise is high for the cycle in which the divider equals P_div−1. Counters advance only on that cycle.
- hcount wraps to 0 after H_total−1 and advances vcount. vcount wraps after V_total−1; the wrap toggles O_frame_odd.
- Odd-frame skip: if ctrl.skip=1, O_frame_odd=1 and vcount=V_total−1, hcount wraps from H_total−2.
- Decode:
  - active = hcount<P_active_h && vcount<P_active_v
  - hsync pulse when hcount ∈ [P_active_h+P_front_h, +P_sync_h)
  - vsync pulse when vcount ∈ [P_active_v+P_front_v, +P_sync_v)
- Registers:
  - addr0 ctrl, R/W: b0 nmi_en, b1 irq_en, b2 skip
  - addr1 status, R: b7 vblank, b6 raster_hit; other bits read 0
  - addr1 write: 1 in b6 clears raster_hit
  - addr2 raster_lo, R/W
  - addr3 raster_hi, R/W: b1:0 only, other bits read 0
- A read of addr1 returns current status, then clears vblank.
- vblank sets on the pixel strobe where the counters become (0, P_vblank_line). vblank and raster_hit both clear where the counters become (0, V_total−1).
- raster_hit sets on the strobe where the counters become (0, {raster_hi[1:0],raster_lo}). The compare value is zero-extended. A value ≥V_total never hits.
- Simultaneous events:
  - vblank set and status read in the same cycle: the set wins; the read returns vblank=0.
  - raster set and a clear-write in the same cycle: the set wins.
  - Frame-end clear and set coincide (P_vblank_line=V_total−1): the set wins.

## Timing
- Reset values:
  - divider 0, hcount 0, vcount 0, frame_odd 0, all registers 0, O_host_data 0
  - O_pix_rise 0, O_active 0
  - O_hsync = ~P_hsync_pol, O_vsync = ~P_vsync_pol
  - O_host_nmi 0, O_raster_irq 0
- Asserting reset mid-frame returns everything to reset values immediately. The first O_pix_rise comes P_div cycles after release.
- Counter outputs change on the clock edge ending a strobe cycle.
- O_active and sync outputs are registered decodes aligned with O_hcount/O_vcount, so they always describe the displayed counters. After reset release they take the decode of (0,0) on the first clock.
- Host write takes effect on the next edge.
- O_host_data is valid the clock after I_host_rden and holds until the next read.
- O_host_nmi and O_raster_irq follow flag or enable changes one clock later.

## Test plan
- Default params, run 2 frames with skip=0 → O_pix_rise every 4 clocks. hsync low for 51 pixels from hcount 265. vsync low on line 245 only. Line 341 pixels, frame 89342 pixels.
- skip=1, 2 frames → the odd frame's line 261 ends at hcount 339, giving 89341 pixels. The even frame is 89342 pixels.
- nmi_en=1 → O_host_nmi rises 1 clock after counters reach (0,241). A status read returns 0x80 and NMI drops. Flag clears at (0,261).
- Status read issued on the exact set cycle → read data b7=0 and vblank stays 1.
- raster=0x064, irq_en=1 → irq at (0,100). Write 0x40 to addr1 clears it. raster=0x3FF never fires.
- Reset pulse mid-line (hcount 150, vcount 30) → all outputs return to reset values; after release, counters restart at (0,0).

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel strobe from a clock divider, h/v counters, registered active/sync decode,
// plus a 4-entry host register file with vblank NMI and raster-line IRQ; no backpressure, free-running.
module video_timing_gen #(
    parameter int P_div         = 4,
    parameter int P_active_h    = 256,
    parameter int P_front_h     = 9,
    parameter int P_sync_h      = 51,
    parameter int P_back_h      = 25,
    parameter int P_active_v    = 240,
    parameter int P_front_v     = 5,
    parameter int P_sync_v      = 1,
    parameter int P_back_v      = 16,
    parameter int P_vblank_line = P_active_v + 1,
    parameter int P_hsync_pol   = 0,
    parameter int P_vsync_pol   = 0,
    parameter int P_cnt_width   = 10
) (
    input  logic                   I_clock,
    input  logic                   I_reset,
    output logic                   O_pix_rise,
    output logic [P_cnt_width-1:0] O_hcount,
    output logic [P_cnt_width-1:0] O_vcount,
    output logic                   O_active,
    output logic                   O_hsync,
    output logic                   O_vsync,
    output logic                   O_frame_odd,
    input  logic [1:0]             I_host_addr,
    input  logic                   I_host_wren,
    input  logic                   I_host_rden,
    input  logic [7:0]             I_host_data,
    output logic [7:0]             O_host_data,
    output logic                   O_host_nmi,
    output logic                   O_raster_irq
);

    localparam int H_TOTAL = P_active_h + P_front_h + P_sync_h + P_back_h;
    localparam int V_TOTAL = P_active_v + P_front_v + P_sync_v + P_back_v;
    localparam int DIV_W   = (P_div > 2) ? $clog2(P_div) : 1;

    typedef logic [P_cnt_width-1:0] cnt_t;
    typedef logic [DIV_W-1:0]       divcnt_t;

    localparam divcnt_t DIV_LAST    = divcnt_t'(P_div - 1);
    localparam cnt_t    H_LAST      = cnt_t'(H_TOTAL - 1);
    localparam cnt_t    H_LAST_SKIP = cnt_t'(H_TOTAL - 2);
    localparam cnt_t    V_LAST      = cnt_t'(V_TOTAL - 1);
    localparam cnt_t    VBL_LINE    = cnt_t'(P_vblank_line);
    localparam int      HS_START    = P_active_h + P_front_h;
    localparam int      HS_END      = HS_START + P_sync_h;
    localparam int      VS_START    = P_active_v + P_front_v;
    localparam int      VS_END      = VS_START + P_sync_v;
    localparam logic    HS_ON       = (P_hsync_pol != 0);
    localparam logic    VS_ON       = (P_vsync_pol != 0);

    divcnt_t    div_q;
    cnt_t       hcnt_q, vcnt_q;
    cnt_t       hcnt_n, vcnt_n;
    cnt_t       h_wrap_at;
    logic       odd_q, odd_n;
    logic       strobe;

    logic [2:0] ctrl_q;
    logic [7:0] raster_lo_q;
    logic [1:0] raster_hi_q;
    logic       vblank_q;
    logic       hit_q;
    logic [7:0] rd_dat;

    logic       line_start;
    logic       vbl_set;
    logic       frame_clr;
    logic       hit_set;
    logic       stat_rd;
    logic       stat_wr;
    logic [9:0] raster_cmp;

    assign strobe      = (div_q == DIV_LAST);
    assign O_pix_rise  = strobe;
    assign O_hcount    = hcnt_q;
    assign O_vcount    = vcnt_q;
    assign O_frame_odd = odd_q;

    // The skipped pixel only exists on the last line of an odd frame.
    always_comb begin
        h_wrap_at = (ctrl_q[2] && odd_q && (vcnt_q == V_LAST)) ? H_LAST_SKIP : H_LAST;
        hcnt_n    = hcnt_q;
        vcnt_n    = vcnt_q;
        odd_n     = odd_q;
        if (strobe) begin
            if (hcnt_q == h_wrap_at) begin
                hcnt_n = '0;
                if (vcnt_q == V_LAST) begin
                    vcnt_n = '0;
                    odd_n  = ~odd_q;
                end else begin
                    vcnt_n = vcnt_q + cnt_t'(1);
                end
            end else begin
                hcnt_n = hcnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            div_q  <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
            odd_q  <= 1'b0;
        end else begin
            div_q  <= strobe ? divcnt_t'(0) : div_q + divcnt_t'(1);
            hcnt_q <= hcnt_n;
            vcnt_q <= vcnt_n;
            odd_q  <= odd_n;
        end
    end

    // Decode from the next counter values so the outputs line up with O_hcount/O_vcount.
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            O_active <= 1'b0;
            O_hsync  <= ~HS_ON;
            O_vsync  <= ~VS_ON;
        end else begin
            O_active <= (int'(hcnt_n) < P_active_h) && (int'(vcnt_n) < P_active_v);
            O_hsync  <= ((int'(hcnt_n) >= HS_START) && (int'(hcnt_n) < HS_END)) ? HS_ON : ~HS_ON;
            O_vsync  <= ((int'(vcnt_n) >= VS_START) && (int'(vcnt_n) < VS_END)) ? VS_ON : ~VS_ON;
        end
    end

    assign line_start = strobe && (hcnt_n == '0);
    assign raster_cmp = {raster_hi_q, raster_lo_q};
    assign vbl_set    = line_start && (vcnt_n == VBL_LINE);
    assign frame_clr  = line_start && (vcnt_n == V_LAST);
    assign hit_set    = line_start && (10'(vcnt_n) == raster_cmp);
    assign stat_rd    = I_host_rden && (I_host_addr == 2'd1);
    assign stat_wr    = I_host_wren && (I_host_addr == 2'd1);

    always_comb begin
        rd_dat = 8'h00;
        case (I_host_addr)
            2'd0: rd_dat = {5'b0, ctrl_q};
            2'd1: rd_dat = {vblank_q, hit_q, 6'b0};
            2'd2: rd_dat = raster_lo_q;
            2'd3: rd_dat = {6'b0, raster_hi_q};
            default: rd_dat = 8'h00;
        endcase
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            ctrl_q      <= '0;
            raster_lo_q <= '0;
            raster_hi_q <= '0;
            O_host_data <= '0;
        end else begin
            if (I_host_wren) begin
                case (I_host_addr)
                    2'd0: ctrl_q      <= I_host_data[2:0];
                    2'd2: raster_lo_q <= I_host_data;
                    2'd3: raster_hi_q <= I_host_data[1:0];
                    default: ;
                endcase
            end
            if (I_host_rden) begin
                O_host_data <= rd_dat;
            end
        end
    end

    // Setting a flag always beats any clear landing in the same cycle.
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            vblank_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            if (vbl_set) begin
                vblank_q <= 1'b1;
            end else if (frame_clr || stat_rd) begin
                vblank_q <= 1'b0;
            end
            if (hit_set) begin
                hit_q <= 1'b1;
            end else if (frame_clr || (stat_wr && I_host_data[6])) begin
                hit_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            O_host_nmi   <= 1'b0;
            O_raster_irq <= 1'b0;
        end else begin
            O_host_nmi   <= vblank_q & ctrl_q[0];
            O_raster_irq <= hit_q & ctrl_q[1];
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced raster (15x10 pixels, 4 clocks per pixel).
module tb_video_timing_gen;

    localparam int DIV = 4;
    localparam int AH = 8, FH = 2, SH = 3, BH = 2;
    localparam int AV = 6, FV = 1, SV = 1, BV = 2;
    localparam int HT = AH + FH + SH + BH;
    localparam int VT = AV + FV + SV + BV;
    localparam int VBL = AV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_rise;
    logic [9:0] hcount, vcount;
    logic       active, hsync, vsync, frame_odd;
    logic [1:0] host_addr = '0;
    logic       host_wren = 1'b0, host_rden = 1'b0;
    logic [7:0] host_wdat = '0;
    logic [7:0] host_rdat;
    logic       nmi, irq;

    int total = 0;
    int bad = 0;

    int flen[4];
    int fodd[4];
    int lastend[4];
    int dec_err, gap_err, hs_low, vs_low;

    always #5 clk = ~clk;

    video_timing_gen #(
        .P_div(DIV), .P_active_h(AH), .P_front_h(FH), .P_sync_h(SH), .P_back_h(BH),
        .P_active_v(AV), .P_front_v(FV), .P_sync_v(SV), .P_back_v(BV),
        .P_vblank_line(VBL), .P_hsync_pol(0), .P_vsync_pol(0), .P_cnt_width(10)
    ) dut (
        .I_clock(clk), .I_reset(rst), .O_pix_rise(pix_rise),
        .O_hcount(hcount), .O_vcount(vcount), .O_active(active),
        .O_hsync(hsync), .O_vsync(vsync), .O_frame_odd(frame_odd),
        .I_host_addr(host_addr), .I_host_wren(host_wren), .I_host_rden(host_rden),
        .I_host_data(host_wdat), .O_host_data(host_rdat),
        .O_host_nmi(nmi), .O_raster_irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
        host_addr = a; host_wdat = d; host_wren = 1'b1;
        @(negedge clk);
        host_wren = 1'b0;
    endtask

    task automatic host_rd(input logic [1:0] a, output logic [7:0] d);
        host_addr = a; host_rden = 1'b1;
        @(negedge clk);
        host_rden = 1'b0;
        d = host_rdat;
    endtask

    task automatic wait_at(input int h, input int v, input bit need_rise, input string name);
        bit found = 1'b0;
        for (int n = 0; n < 1500 && !found; n++) begin
            @(negedge clk);
            if (hcount == h && vcount == v && (!need_rise || pix_rise)) found = 1'b1;
        end
        chk(name, found, 1);
    endtask

    task automatic measure(input int nfr, input string name);
        int pix, f, guard, gap;
        bit seen_rise;
        logic [9:0] ph, pv;
        int odd_start;
        logic exp_act, exp_hs, exp_vs;
        dec_err = 0; gap_err = 0; hs_low = 0; vs_low = 0;
        wait_at(0, 0, 0, {name, "_sync"});
        ph = 0; pv = 0; pix = 1; f = 0; guard = 0; gap = 0; seen_rise = 0;
        odd_start = int'(frame_odd);
        while (f < nfr && guard < 4000) begin
            @(negedge clk);
            guard++;
            gap++;
            exp_act = (hcount < AH) && (vcount < AV);
            exp_hs  = !((hcount >= AH + FH) && (hcount < AH + FH + SH));
            exp_vs  = !((vcount >= AV + FV) && (vcount < AV + FV + SV));
            if (active !== exp_act || hsync !== exp_hs || vsync !== exp_vs) dec_err++;
            if (pix_rise) begin
                if (seen_rise && gap != DIV) gap_err++;
                gap = 0;
                seen_rise = 1;
            end
            if (hcount != ph || vcount != pv) begin
                if (hcount == 0 && vcount == 0) begin
                    flen[f] = pix; fodd[f] = odd_start; lastend[f] = int'(ph);
                    f++;
                    pix = 0;
                    odd_start = int'(frame_odd);
                end
                pix++;
                if (!hsync) hs_low++;
                if (!vsync) vs_low++;
                ph = hcount; pv = vcount;
            end
        end
        chk({name, "_done"}, f, nfr);
    endtask

    typedef struct {
        logic [1:0] addr;
        logic [7:0] wdat;
        logic [7:0] rexp;
    } reg_vec_t;

    reg_vec_t vt[9];

    initial begin
        logic [7:0] d;
        int n;

        vt[0] = '{2'd0, 8'h07, 8'h07};
        vt[1] = '{2'd0, 8'hF8, 8'h00};
        vt[2] = '{2'd0, 8'h05, 8'h05};
        vt[3] = '{2'd2, 8'hA5, 8'hA5};
        vt[4] = '{2'd2, 8'h3C, 8'h3C};
        vt[5] = '{2'd3, 8'hFF, 8'h03};
        vt[6] = '{2'd3, 8'hFE, 8'h02};
        vt[7] = '{2'd1, 8'h00, 8'h00};
        vt[8] = '{2'd0, 8'h00, 8'h00};

        repeat (3) @(negedge clk);
        chk("rst_pix_rise", pix_rise, 0);
        chk("rst_hcount", hcount, 0);
        chk("rst_vcount", vcount, 0);
        chk("rst_active", active, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_odd", frame_odd, 0);
        chk("rst_host_data", host_rdat, 0);
        chk("rst_nmi", nmi, 0);
        chk("rst_irq", irq, 0);

        rst = 1'b0;
        @(negedge clk);
        chk("first_clk_active", active, 1);
        chk("first_clk_hsync", hsync, 1);
        n = 1;
        while (!pix_rise && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_rise_edges", n, DIV - 1);

        for (int i = 0; i < 9; i++) begin
            host_wr(vt[i].addr, vt[i].wdat);
            host_rd(vt[i].addr, d);
            chk($sformatf("reg_vec%0d", i), d, vt[i].rexp);
        end

        measure(2, "noskip");
        chk("noskip_len0", flen[0], HT * VT);
        chk("noskip_len1", flen[1], HT * VT);
        chk("decode_err", dec_err, 0);
        chk("strobe_gap_err", gap_err, 0);
        chk("hsync_low_pixels", hs_low, 2 * VT * SH);
        chk("vsync_low_pixels", vs_low, 2 * HT * SV);

        host_wr(2'd0, 8'h04);
        measure(2, "skip");
        chk("skip_parity_alt", fodd[0] ^ fodd[1], 1);
        for (int f = 0; f < 2; f++) begin
            chk($sformatf("skip_len%0d", f), flen[f], fodd[f] ? HT * VT - 1 : HT * VT);
            chk($sformatf("skip_lastend%0d", f), lastend[f], fodd[f] ? HT - 2 : HT - 1);
        end

        host_wr(2'd0, 8'h01);
        wait_at(0, VBL, 0, "nmi_reach_vbl");
        chk("nmi_lag", nmi, 0);
        @(negedge clk);
        chk("nmi_rise", nmi, 1);
        host_rd(2'd1, d);
        chk("status_vbl", d, 8'h80);
        @(negedge clk);
        chk("nmi_drop_on_read", nmi, 0);

        wait_at(0, VBL, 0, "nmi_reach_vbl2");
        @(negedge clk);
        chk("nmi_rise2", nmi, 1);
        wait_at(0, VT - 1, 0, "nmi_reach_end");
        chk("nmi_before_clr", nmi, 1);
        @(negedge clk);
        chk("nmi_frame_clr", nmi, 0);
        host_rd(2'd1, d);
        chk("status_after_clr", d, 8'h00);

        wait_at(HT - 1, VBL - 1, 1, "rd_set_cycle");
        host_addr = 2'd1; host_rden = 1'b1;
        @(negedge clk);
        host_rden = 1'b0;
        chk("rd_on_set_data", host_rdat, 8'h00);
        chk("rd_on_set_line", vcount, VBL);
        @(negedge clk);
        chk("vbl_survives_read", nmi, 1);
        host_rd(2'd1, d);
        chk("vbl_still_set", d, 8'h80);
        host_wr(2'd0, 8'h00);

        host_wr(2'd3, 8'h00);
        host_wr(2'd2, 8'h04);
        host_wr(2'd1, 8'h40);
        host_wr(2'd0, 8'h02);
        wait_at(0, 4, 0, "irq_reach_line");
        chk("irq_lag", irq, 0);
        @(negedge clk);
        chk("irq_rise", irq, 1);
        host_rd(2'd1, d);
        chk("status_hit", d, 8'h40);
        host_wr(2'd1, 8'h40);
        @(negedge clk);
        chk("irq_clr_write", irq, 0);

        wait_at(HT - 1, 3, 1, "collide_cycle");
        host_addr = 2'd1; host_wdat = 8'h40; host_wren = 1'b1;
        @(negedge clk);
        host_wren = 1'b0;
        chk("collide_line", vcount, 4);
        @(negedge clk);
        chk("set_beats_clear", irq, 1);
        host_rd(2'd1, d);
        chk("collide_status", d, 8'h40);

        host_wr(2'd2, 8'hFF);
        host_wr(2'd3, 8'hFF);
        host_wr(2'd1, 8'h40);
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 2 * HT * VT * DIV; i++) begin
            @(negedge clk);
            if (irq) n++;
        end
        chk("raster_3ff_never", n, 0);
        host_rd(2'd1, d);
        chk("raster_3ff_flag", d[6], 0);

        host_wr(2'd0, 8'h07);
        host_rd(2'd0, d);
        chk("pre_reset_ctrl", d, 8'h07);
        wait_at(12, 4, 0, "reach_midline");
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_hcount", hcount, 0);
        chk("mid_rst_vcount", vcount, 0);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_syncs", {hsync, vsync}, 2'b11);
        chk("mid_rst_host_data", host_rdat, 0);
        chk("mid_rst_pix_rise", pix_rise, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_origin", {hcount, vcount}, 20'h0);
        host_rd(2'd0, d);
        chk("restart_ctrl", d, 8'h00);
        wait_at(1, 0, 0, "restart_first_pixel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
